// File: rtl/dump_uart_sink_if.sv
// WISHBONE classic bus between the memory-dump master and the UART dump sink.
interface dump_uart_sink_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [29:0] ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] slave_DAT_I;
  logic [31:0] slave_DAT_O;
  logic        ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, SEL_I, slave_DAT_I,
    input  slave_DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, slave_DAT_I,
    output slave_DAT_O, ACK_O
  );
endinterface

// File: rtl/dump_uart_sink.sv
// WISHBONE byte sink: bytes written to BASE_ADR are queued in a FIFO and sent
// out as 8N1 serial frames; reads of the same address return a status word.
module dump_uart_sink #(
  parameter logic [29:0] BASE_ADR = 30'h4000800,
  parameter logic [15:0] CLK_DIV  = 16'd434,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic             CLK_I,
  input  logic             reset_n,
  dump_uart_sink_if.slave  wb,
  output logic             uart_txd,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int unsigned        DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
  localparam logic [15:0]        CNT_LAST = CLK_DIV - 16'd1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_o_q, dat_o_d;
  tx_state_e          state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               txd_q, txd_d;
  logic               hit, full, empty, push, pop, tx_busy, baud_tick;
  logic               unused_bits;

  assign unused_bits = ^{wb.SEL_I[2:0], wb.slave_DAT_I[23:0]};

  // The ~ack_q term keeps a still-asserted STB from producing a second
  // transfer in the cycle after ACK.
  always_comb begin
    hit     = wb.CYC_I & wb.STB_I & (wb.ADR_I == BASE_ADR);
    full    = (level_q == LVL_FULL);
    empty   = (level_q == '0);
    tx_busy = (state_q != TX_IDLE);
    push    = hit & ~ack_q & wb.WE_I & wb.SEL_I[3] & ~full;
    ack_d   = hit & ~ack_q & (~wb.WE_I | ~full | ~wb.SEL_I[3]);
    pop     = (state_q == TX_IDLE) & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dat_o_d  = dat_o_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (ack_d && !wb.WE_I)
      dat_o_d = {16'd0, 8'(level_q), 5'd0, tx_busy, full, empty};
  end

  // Line is registered from the current state, so it trails the state by one
  // cycle; every bit still lasts exactly CLK_DIV cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    baud_tick = (cnt_q == CNT_LAST);
    case (state_q)
      TX_IDLE: begin
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_tick) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = sh_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
    end
  end

  // FIFO storage and shift register carry data only and need no reset.
  always_ff @(posedge CLK_I) begin
    sh_q <= sh_d;
    if (push) mem_q[wr_ptr_q] <= wb.slave_DAT_I[31:24];
  end

  assign uart_txd       = txd_q;
  assign fifo_level     = level_q;
  assign wb.ACK_O       = ack_q;
  assign wb.slave_DAT_O = dat_o_q;

endmodule
